eth_rx_ctrl: RTL and testbench

ETH_RX_CTRL -- requirements
Module: eth_rx_ctrl

---
 rtl/eth_pkg.sv | 14 +
 rtl/sat_cnt.sv | 20 ++
 rtl/eth_rx_ctrl.sv | 177 +++++++++++++++++
 tb/tb_eth_rx_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive path: controller states and frame length limit.
package eth_pkg;

  typedef enum logic [2:0] {
    DISABLED,
    WAIT_IDLE,
    IDLE,
    FRAME,
    DROP
  } rx_state_e;

  localparam int MAX_BEATS_DEFAULT = 761;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter used for receive frame statistics.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count one per inc pulse and stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (nreset) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/eth_rx_ctrl.sv
// Receive controller between PCS and MAC: gates beats to whole frames, flags aborted frames
// with a one-cycle cancel pulse and keeps good/dropped frame statistics.
module eth_rx_ctrl
  import eth_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int LANE0_CNT_N = 1,
  parameter int MAX_BEATS   = MAX_BEATS_DEFAULT,
  parameter int STAT_W      = 32
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   en_i,
  input  logic                   phy_valid_i,
  input  logic                   phy_ctrl_v_i,
  input  logic                   phy_idle_i,
  input  logic                   phy_term_i,
  input  logic                   phy_cancel_i,
  input  logic [DATA_W-1:0]      phy_data_i,
  input  logic [LANE0_CNT_N-1:0] phy_start_i,
  input  logic [KEEP_W-1:0]      phy_term_keep_i,
  output logic                   mac_valid_o,
  output logic                   mac_ctrl_v_o,
  output logic                   mac_idle_o,
  output logic                   mac_term_o,
  output logic                   mac_cancel_o,
  output logic [DATA_W-1:0]      mac_data_o,
  output logic [LANE0_CNT_N-1:0] mac_start_o,
  output logic [KEEP_W-1:0]      mac_term_keep_o,
  output logic [STAT_W-1:0]      frame_ok_cnt_o,
  output logic [STAT_W-1:0]      frame_drop_cnt_o,
  output logic                   busy_o
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  rx_state_e        state;
  rx_state_e        state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_next;
  logic             fwd;
  logic             cancel_pulse;
  logic             ok_inc;
  logic             drop_inc;
  logic             has_start;

  assign has_start = |phy_start_i;
  assign busy_o    = (state == FRAME);

  // State and per-frame beat counter registers
  always_ff @(posedge clk) begin
    if (nreset) begin
      state    <= DISABLED;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  // Next state, forward decision and statistics pulses; inside a frame the order is
  // disable, then PCS cancel, then term, then a stray start, then length overflow
  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    fwd           = 1'b0;
    cancel_pulse  = 1'b0;
    ok_inc        = 1'b0;
    drop_inc      = 1'b0;

    if (!en_i) begin
      state_next    = DISABLED;
      beat_cnt_next = '0;
      if (state == FRAME) begin
        cancel_pulse = 1'b1;
        drop_inc     = 1'b1;
      end
    end else begin
      unique case (state)
        DISABLED: begin
          state_next = WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (phy_valid_i && phy_idle_i) begin
            state_next = IDLE;
          end
        end
        IDLE: begin
          if (phy_valid_i) begin
            if (has_start) begin
              fwd           = 1'b1;
              state_next    = FRAME;
              beat_cnt_next = CNT_W'(1);
            end else if (phy_idle_i) begin
              fwd = 1'b1;
            end
          end
        end
        FRAME: begin
          if (phy_cancel_i) begin
            cancel_pulse  = 1'b1;
            drop_inc      = 1'b1;
            state_next    = WAIT_IDLE;
            beat_cnt_next = '0;
          end else if (phy_valid_i) begin
            if (phy_term_i) begin
              fwd           = 1'b1;
              ok_inc        = 1'b1;
              state_next    = IDLE;
              beat_cnt_next = '0;
            end else if (has_start || (beat_cnt == CNT_W'(MAX_BEATS))) begin
              cancel_pulse  = 1'b1;
              drop_inc      = 1'b1;
              state_next    = DROP;
              beat_cnt_next = '0;
            end else begin
              fwd           = 1'b1;
              beat_cnt_next = beat_cnt + CNT_W'(1);
            end
          end
        end
        DROP: begin
          if (phy_valid_i && (phy_idle_i || phy_term_i)) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next    = DISABLED;
          beat_cnt_next = '0;
        end
      endcase
    end
  end

  // Registered MAC side: forwarded beats pass one cycle late, everything else is zeroed
  always_ff @(posedge clk) begin
    if (nreset) begin
      mac_valid_o     <= 1'b0;
      mac_ctrl_v_o    <= 1'b0;
      mac_idle_o      <= 1'b0;
      mac_term_o      <= 1'b0;
      mac_cancel_o    <= 1'b0;
      mac_data_o      <= '0;
      mac_start_o     <= '0;
      mac_term_keep_o <= '0;
    end else begin
      mac_valid_o     <= fwd;
      mac_ctrl_v_o    <= fwd & phy_ctrl_v_i;
      mac_idle_o      <= fwd & phy_idle_i;
      mac_term_o      <= fwd & phy_term_i;
      mac_cancel_o    <= cancel_pulse;
      mac_data_o      <= fwd ? phy_data_i : '0;
      mac_start_o     <= fwd ? phy_start_i : '0;
      mac_term_keep_o <= fwd ? phy_term_keep_i : '0;
    end
  end

  sat_cnt #(
    .W(STAT_W)
  ) u_ok_cnt (
    .clk   (clk),
    .nreset(nreset),
    .inc   (ok_inc),
    .cnt   (frame_ok_cnt_o)
  );

  sat_cnt #(
    .W(STAT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .nreset(nreset),
    .inc   (drop_inc),
    .cnt   (frame_drop_cnt_o)
  );

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Directed bench for eth_rx_ctrl: a default-parameter instance driven from a vector table,
// plus a short-frame, 2-bit-statistics instance exercised by hand-written sequences.
module tb_eth_rx_ctrl;

  localparam int K_NONE  = 0;
  localparam int K_IDLE  = 1;
  localparam int K_START = 2;
  localparam int K_DATA  = 3;
  localparam int K_TERM  = 4;

  typedef struct {
    logic        rst;
    logic        en;
    logic        canc;
    int          kind;
    logic [15:0] data;
    logic        x_valid;
    logic [8:0]  x_quals;
    logic [15:0] x_data;
    int          x_ok;
    int          x_drop;
  } vec_t;

  vec_t tbl[$];
  int   eok;
  int   edrop;
  int   checks;
  int   errors;

  logic        clk;
  logic        nreset;
  logic        en;
  logic        valid;
  logic        ctrl_v;
  logic        idle;
  logic        term;
  logic        cancel;
  logic [15:0] data;
  logic [0:0]  start;
  logic [1:0]  keep;

  logic        a_valid, a_ctrl_v, a_idle, a_term, a_cancel, a_busy;
  logic [15:0] a_data;
  logic [0:0]  a_start;
  logic [1:0]  a_keep;
  logic [31:0] a_ok, a_drop;

  logic        b_valid, b_ctrl_v, b_idle, b_term, b_cancel, b_busy;
  logic [15:0] b_data;
  logic [0:0]  b_start;
  logic [1:0]  b_keep;
  logic [1:0]  b_ok, b_drop;

  logic [8:0]  a_quals;
  logic [8:0]  b_quals;

  assign a_quals = {a_valid, a_ctrl_v, a_idle, a_term, a_cancel, a_start, a_keep, a_busy};
  assign b_quals = {b_valid, b_ctrl_v, b_idle, b_term, b_cancel, b_start, b_keep, b_busy};

  eth_rx_ctrl dut_a (
    .clk             (clk),
    .nreset          (nreset),
    .en_i            (en),
    .phy_valid_i     (valid),
    .phy_ctrl_v_i    (ctrl_v),
    .phy_idle_i      (idle),
    .phy_term_i      (term),
    .phy_cancel_i    (cancel),
    .phy_data_i      (data),
    .phy_start_i     (start),
    .phy_term_keep_i (keep),
    .mac_valid_o     (a_valid),
    .mac_ctrl_v_o    (a_ctrl_v),
    .mac_idle_o      (a_idle),
    .mac_term_o      (a_term),
    .mac_cancel_o    (a_cancel),
    .mac_data_o      (a_data),
    .mac_start_o     (a_start),
    .mac_term_keep_o (a_keep),
    .frame_ok_cnt_o  (a_ok),
    .frame_drop_cnt_o(a_drop),
    .busy_o          (a_busy)
  );

  eth_rx_ctrl #(
    .MAX_BEATS(8),
    .STAT_W   (2)
  ) dut_b (
    .clk             (clk),
    .nreset          (nreset),
    .en_i            (en),
    .phy_valid_i     (valid),
    .phy_ctrl_v_i    (ctrl_v),
    .phy_idle_i      (idle),
    .phy_term_i      (term),
    .phy_cancel_i    (cancel),
    .phy_data_i      (data),
    .phy_start_i     (start),
    .phy_term_keep_i (keep),
    .mac_valid_o     (b_valid),
    .mac_ctrl_v_o    (b_ctrl_v),
    .mac_idle_o      (b_idle),
    .mac_term_o      (b_term),
    .mac_cancel_o    (b_cancel),
    .mac_data_o      (b_data),
    .mac_start_o     (b_start),
    .mac_term_keep_o (b_keep),
    .frame_ok_cnt_o  (b_ok),
    .frame_drop_cnt_o(b_drop),
    .busy_o          (b_busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] expQuals(input logic fwd, input int kind, input logic xcancel,
                                          input logic xbusy);
    logic       q_ctrl;
    logic [1:0] q_keep;
    q_ctrl = fwd && ((kind == K_IDLE) || (kind == K_START) || (kind == K_TERM));
    q_keep = (fwd && (kind == K_TERM)) ? 2'b01 : 2'b00;
    return {fwd, q_ctrl, fwd && (kind == K_IDLE), fwd && (kind == K_TERM), xcancel,
            fwd && (kind == K_START), q_keep, xbusy};
  endfunction

  task automatic addVec(input logic rst, input logic en_v, input int kind, input logic [15:0] d,
                        input logic canc, input logic fwd, input logic xcancel, input logic xbusy);
    vec_t v;
    v.rst     = rst;
    v.en      = en_v;
    v.canc    = canc;
    v.kind    = kind;
    v.data    = d;
    v.x_valid = fwd;
    v.x_quals = expQuals(fwd, kind, xcancel, xbusy);
    v.x_data  = d;
    v.x_ok    = eok;
    v.x_drop  = edrop;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    nreset = v.rst;
    en     = v.en;
    cancel = v.canc;
    valid  = (v.kind != K_NONE);
    idle   = (v.kind == K_IDLE);
    term   = (v.kind == K_TERM);
    start  = (v.kind == K_START);
    ctrl_v = (v.kind == K_IDLE) || (v.kind == K_START) || (v.kind == K_TERM);
    keep   = (v.kind == K_TERM) ? 2'b01 : 2'b00;
    data   = v.data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkValue($sformatf("vec%0d_quals", idx), 32'(a_quals), 32'(v.x_quals));
    if (v.x_valid) checkValue($sformatf("vec%0d_data", idx), 32'(a_data), 32'(v.x_data));
    checkValue($sformatf("vec%0d_ok", idx), a_ok, 32'(v.x_ok));
    checkValue($sformatf("vec%0d_drop", idx), a_drop, 32'(v.x_drop));
  endtask

  task automatic stepB(input string name, input logic rst, input logic en_v, input int kind,
                       input logic [15:0] d, input logic canc, input logic fwd,
                       input logic xcancel, input logic xbusy);
    vec_t v;
    v.rst  = rst;
    v.en   = en_v;
    v.canc = canc;
    v.kind = kind;
    v.data = d;
    applyStimulus(v);
    checkValue({name, "_quals"}, 32'(b_quals), 32'(expQuals(fwd, kind, xcancel, xbusy)));
    if (fwd) checkValue({name, "_data"}, 32'(b_data), 32'(d));
  endtask

  // Directed test sequence
  initial begin
    checks = 0;
    errors = 0;
    nreset = 1'b1;
    en     = 1'b0;
    valid  = 1'b0;
    ctrl_v = 1'b0;
    idle   = 1'b0;
    term   = 1'b0;
    cancel = 1'b0;
    data   = '0;
    start  = '0;
    keep   = '0;

    // Reset, then enable, idle, start, ten data beats, term
    eok = 0; edrop = 0;
    addVec(1, 0, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(1, 0, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(0, 1, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 1, 0, 0);
    addVec(0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) addVec(0, 1, K_DATA, 16'h1000 + 16'(i), 0, 1, 0, 1);
    eok = 1;
    addVec(0, 1, K_TERM, 16'h00FD, 0, 1, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 1, 0, 0);

    // Enable in the middle of a frame: nothing passes until an idle is seen
    eok = 0; edrop = 0;
    addVec(1, 0, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(0, 1, K_DATA, 16'hAAAA, 0, 0, 0, 0);
    addVec(0, 1, K_DATA, 16'hBBBB, 0, 0, 0, 0);
    addVec(0, 1, K_TERM, 16'h00FD, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 1, 0, 0);
    addVec(0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    addVec(0, 1, K_DATA, 16'h2001, 0, 1, 0, 1);
    addVec(0, 1, K_DATA, 16'h2002, 0, 1, 0, 1);
    eok = 1;
    addVec(0, 1, K_TERM, 16'h00FD, 0, 1, 0, 0);

    // PCS cancel together with term on beat 5; cancel outside a frame is ignored;
    // an invalid beat inside a frame holds state
    eok = 0; edrop = 0;
    addVec(1, 0, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(0, 1, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    addVec(0, 1, K_DATA, 16'h3002, 0, 1, 0, 1);
    addVec(0, 1, K_DATA, 16'h3003, 0, 1, 0, 1);
    addVec(0, 1, K_DATA, 16'h3004, 0, 1, 0, 1);
    edrop = 1;
    addVec(0, 1, K_TERM, 16'h00FD, 1, 0, 1, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 1, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 1, 1, 0, 0);
    addVec(0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    addVec(0, 1, K_NONE, 16'h0000, 0, 0, 0, 1);
    addVec(0, 1, K_DATA, 16'h3102, 0, 1, 0, 1);
    eok = 1;
    addVec(0, 1, K_TERM, 16'h00FD, 0, 1, 0, 0);

    // Enable dropped on beat 3: cancel pulse, one drop, back through DISABLED
    eok = 0; edrop = 0;
    addVec(1, 0, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(0, 1, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    addVec(0, 1, K_DATA, 16'h4002, 0, 1, 0, 1);
    edrop = 1;
    addVec(0, 0, K_DATA, 16'h4003, 0, 0, 1, 0);
    addVec(0, 0, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 1, 0, 0);

    // Reset on beat 3 instead: no cancel pulse and counters cleared
    eok = 0; edrop = 0;
    addVec(1, 0, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(0, 1, K_NONE, 16'h0000, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    addVec(0, 1, K_DATA, 16'h5002, 0, 1, 0, 1);
    addVec(1, 1, K_DATA, 16'h5003, 0, 0, 0, 0);
    addVec(0, 1, K_NONE, 16'h0000, 0, 0, 0, 0);

    // Second start without term drops the frame; DROP leaves on term
    addVec(0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    addVec(0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    addVec(0, 1, K_DATA, 16'h6002, 0, 1, 0, 1);
    edrop = 1;
    addVec(0, 1, K_START, 16'h55D5, 0, 0, 1, 0);
    addVec(0, 1, K_DATA, 16'h6004, 0, 0, 0, 0);
    addVec(0, 1, K_TERM, 16'h00FD, 0, 0, 0, 0);
    addVec(0, 1, K_IDLE, 16'h0707, 0, 1, 0, 0);
    addVec(0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    eok = 1;
    addVec(0, 1, K_TERM, 16'h00FD, 0, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput(i, tbl[i]);
    end

    // Overflow on an 8-beat limit with a 12-beat frame, then a normal frame
    stepB("ovf_rst", 1, 0, K_NONE, 16'h0000, 0, 0, 0, 0);
    stepB("ovf_en", 0, 1, K_NONE, 16'h0000, 0, 0, 0, 0);
    stepB("ovf_wait", 0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    stepB("ovf_idle", 0, 1, K_IDLE, 16'h0707, 0, 1, 0, 0);
    for (int b = 1; b <= 12; b++) begin
      int          k;
      logic [15:0] d;
      k = (b == 1) ? K_START : ((b == 12) ? K_TERM : K_DATA);
      d = 16'h7000 + 16'(b);
      if (b <= 8) stepB($sformatf("ovf_beat%0d", b), 0, 1, k, d, 0, 1, 0, 1);
      else if (b == 9) stepB("ovf_beat9", 0, 1, k, d, 0, 0, 1, 0);
      else stepB($sformatf("ovf_beat%0d", b), 0, 1, k, d, 0, 0, 0, 0);
    end
    checkValue("ovf_drop", 32'(b_drop), 32'd1);
    checkValue("ovf_ok", 32'(b_ok), 32'd0);
    stepB("ovf_after_idle", 0, 1, K_IDLE, 16'h0707, 0, 1, 0, 0);
    stepB("ovf_next_start", 0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    stepB("ovf_next_data", 0, 1, K_DATA, 16'h7101, 0, 1, 0, 1);
    stepB("ovf_next_term", 0, 1, K_TERM, 16'h00FD, 0, 1, 0, 0);
    checkValue("ovf_next_ok", 32'(b_ok), 32'd1);

    // A frame of exactly the limit length is accepted
    stepB("max_start", 0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
    for (int b = 2; b <= 7; b++) stepB($sformatf("max_beat%0d", b), 0, 1, K_DATA, 16'h7200 + 16'(b), 0, 1, 0, 1);
    stepB("max_term", 0, 1, K_TERM, 16'h00FD, 0, 1, 0, 0);
    checkValue("max_ok", 32'(b_ok), 32'd2);
    checkValue("max_drop", 32'(b_drop), 32'd1);

    // Two-bit statistics saturate at 3 after five good frames
    stepB("sat_rst", 1, 0, K_NONE, 16'h0000, 0, 0, 0, 0);
    checkValue("sat_rst_ok", 32'(b_ok), 32'd0);
    stepB("sat_en", 0, 1, K_NONE, 16'h0000, 0, 0, 0, 0);
    stepB("sat_wait", 0, 1, K_IDLE, 16'h0707, 0, 0, 0, 0);
    for (int f = 1; f <= 5; f++) begin
      stepB($sformatf("sat_start%0d", f), 0, 1, K_START, 16'h55D5, 0, 1, 0, 1);
      stepB($sformatf("sat_term%0d", f), 0, 1, K_TERM, 16'h00FD, 0, 1, 0, 0);
      checkValue($sformatf("sat_ok%0d", f), 32'(b_ok), (f < 3) ? 32'(f) : 32'd3);
    end
    checkValue("sat_drop", 32'(b_drop), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
